// File: rtl/sim_check_monitor.sv
// Multi-channel sim-call monitor: classifies per-hart check calls, keeps pass/fail/drop
// counters, runs the IDLE/RUN/END test lifecycle and logs failure records in a FWFT FIFO.

module sim_check_lane #(
    parameter int             XLEN      = 32,
    parameter logic [XLEN-1:0] DONE_CODE = XLEN'(32'h0D15EA5E),
    parameter logic [XLEN-1:0] FAIL_CODE = XLEN'(32'hDEADBEEF)
) (
    input  logic            valid_i,
    input  logic [XLEN-1:0] code_i,
    input  logic [XLEN-1:0] a_i,
    input  logic [XLEN-1:0] b_i,
    output logic            pass_o,
    output logic            fail_o,
    output logic            rec_o,
    output logic            done_o,
    output logic            fatal_o
);
    logic is_zero, is_one, is_done, is_fatal, eq;

    assign is_zero  = (code_i == '0);
    assign is_one   = (code_i == XLEN'(1));
    assign is_done  = (code_i == DONE_CODE);
    assign is_fatal = (code_i == FAIL_CODE);
    assign eq       = (a_i == b_i);

    assign pass_o  = valid_i && is_zero && eq;
    assign fail_o  = valid_i && ((is_zero && !eq) || is_one || is_fatal);
    assign done_o  = valid_i && is_done;
    assign fatal_o = valid_i && is_fatal;
    // Anything that is neither a passing compare nor DONE leaves a record.
    assign rec_o   = valid_i && !(is_zero && eq) && !is_done;
endmodule

module sim_check_monitor #(
    parameter int              NUM_CH     = 2,
    parameter int              XLEN       = 32,
    parameter int              MAX_CYCLES = 2048,
    parameter int              CNT_WIDTH  = 16,
    parameter int              LOG_DEPTH  = 8,
    parameter logic [XLEN-1:0] DONE_CODE  = XLEN'(32'h0D15EA5E),
    parameter logic [XLEN-1:0] FAIL_CODE  = XLEN'(32'hDEADBEEF),
    localparam int             CCW        = $clog2(MAX_CYCLES+1)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic [NUM_CH-1:0]      call_valid,
    input  logic [NUM_CH*XLEN-1:0] call_code,
    input  logic [NUM_CH*XLEN-1:0] call_pc,
    input  logic [NUM_CH*XLEN-1:0] cmp_a,
    input  logic [NUM_CH*XLEN-1:0] cmp_b,
    output logic                   log_valid,
    input  logic                   log_ready,
    output logic [2:0]             log_ch,
    output logic [XLEN-1:0]        log_pc,
    output logic [XLEN-1:0]        log_code,
    output logic [CNT_WIDTH-1:0]   pass_count,
    output logic [CNT_WIDTH-1:0]   fail_count,
    output logic [CNT_WIDTH-1:0]   drop_count,
    output logic [CCW-1:0]         cycle_count,
    output logic                   running,
    output logic                   finished,
    output logic                   passed,
    output logic                   timeout
);
    localparam int NW  = $clog2(NUM_CH+1);
    localparam int PW  = $clog2(LOG_DEPTH);
    localparam int LCW = $clog2(LOG_DEPTH+1);

    typedef enum logic [1:0] {IDLE, RUN, END} state_e;

    typedef struct packed {
        logic [2:0]      ch;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] code;
    } rec_t;

    function automatic logic [CNT_WIDTH-1:0] sat_add(input logic [CNT_WIDTH-1:0] a,
                                                     input logic [NW-1:0] b);
        logic [CNT_WIDTH:0] s;
        s = {1'b0, a} + (CNT_WIDTH+1)'(b);
        return s[CNT_WIDTH] ? '1 : s[CNT_WIDTH-1:0];
    endfunction

    state_e                  state_q;
    logic [CCW-1:0]          cycle_q;
    logic [NUM_CH-1:0]       done_q, done_d;
    logic [CNT_WIDTH-1:0]    pass_q, fail_q, drop_q, pass_d, fail_d, drop_d;
    logic                    running_q, finished_q, passed_q, timeout_q;

    logic [NUM_CH-1:0][XLEN-1:0] code_a, pc_a, a_a, b_a;
    logic [NUM_CH-1:0]       pass_v, fail_v, rec_v, done_v, fatal_v;
    logic                    run, limit, all_done, fatal, leave;
    logic [NW-1:0]           n_pass, n_fail, n_rec, n_drop;
    logic                    push_req, push_ok, pop;
    rec_t                    push_rec, head_d, head_q;
    logic                    head_vld_d, head_vld_q;

    rec_t                    mem [LOG_DEPTH];
    logic [PW-1:0]           rd_q, wr_q, rd_d, wr_d;
    logic [LCW-1:0]          fcnt_q, fcnt_d;

    assign code_a = call_code;
    assign pc_a   = call_pc;
    assign a_a    = cmp_a;
    assign b_a    = cmp_b;
    assign run    = (state_q == RUN);

    for (genvar g = 0; g < NUM_CH; g++) begin : g_lane
        sim_check_lane #(.XLEN(XLEN), .DONE_CODE(DONE_CODE), .FAIL_CODE(FAIL_CODE)) u_lane (
            .valid_i (call_valid[g] && run),
            .code_i  (code_a[g]),
            .a_i     (a_a[g]),
            .b_i     (b_a[g]),
            .pass_o  (pass_v[g]),
            .fail_o  (fail_v[g]),
            .rec_o   (rec_v[g]),
            .done_o  (done_v[g]),
            .fatal_o (fatal_v[g])
        );
    end

    always_comb begin
        n_pass   = '0;
        n_fail   = '0;
        n_rec    = '0;
        push_rec = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            n_pass = n_pass + NW'(pass_v[i]);
            n_fail = n_fail + NW'(fail_v[i]);
            n_rec  = n_rec + NW'(rec_v[i]);
        end
        // Descending scan so the lowest failing channel ends up owning the push.
        for (int i = NUM_CH-1; i >= 0; i--) begin
            if (rec_v[i]) push_rec = '{ch: 3'(i), pc: pc_a[i], code: code_a[i]};
        end
        push_req = |rec_v;
        pop      = head_vld_q && log_ready;
        push_ok  = push_req && ((fcnt_q != LCW'(LOG_DEPTH)) || pop);
        n_drop   = n_rec - NW'(push_req) + NW'(push_req && !push_ok);

        done_d   = done_q | done_v;
        all_done = &done_d;
        fatal    = |fatal_v;
        limit    = run && (cycle_q == CCW'(MAX_CYCLES-1));
        leave    = run && (all_done || fatal || limit);
        pass_d   = sat_add(pass_q, n_pass);
        fail_d   = sat_add(fail_q, n_fail);
        drop_d   = sat_add(drop_q, n_drop);

        fcnt_d = fcnt_q + LCW'(push_ok) - LCW'(pop);
        rd_d   = rd_q + PW'(pop);
        wr_d   = wr_q + PW'(push_ok);
        head_vld_d = (fcnt_d != '0);
        if (!head_vld_d)                      head_d = '0;
        else if ((fcnt_q - LCW'(pop)) == '0)  head_d = push_rec;
        else                                  head_d = mem[rd_d];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cycle_q    <= '0;
            done_q     <= '0;
            pass_q     <= '0;
            fail_q     <= '0;
            drop_q     <= '0;
            running_q  <= 1'b0;
            finished_q <= 1'b0;
            passed_q   <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            pass_q <= pass_d;
            fail_q <= fail_d;
            drop_q <= drop_d;
            done_q <= done_d;
            case (state_q)
                IDLE: if (start) begin
                    state_q   <= RUN;
                    running_q <= 1'b1;
                end
                RUN: begin
                    if (!limit) cycle_q <= cycle_q + 1'b1;
                    if (leave) begin
                        state_q    <= END;
                        running_q  <= 1'b0;
                        finished_q <= 1'b1;
                        timeout_q  <= !(all_done || fatal);
                        passed_q   <= (fail_d == '0) && all_done;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_q       <= '0;
            wr_q       <= '0;
            fcnt_q     <= '0;
            head_q     <= '0;
            head_vld_q <= 1'b0;
        end else begin
            rd_q       <= rd_d;
            wr_q       <= wr_d;
            fcnt_q     <= fcnt_d;
            head_q     <= head_d;
            head_vld_q <= head_vld_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_q] <= push_rec;
    end

    assign log_valid   = head_vld_q;
    assign log_ch      = head_q.ch;
    assign log_pc      = head_q.pc;
    assign log_code    = head_q.code;
    assign pass_count  = pass_q;
    assign fail_count  = fail_q;
    assign drop_count  = drop_q;
    assign cycle_count = cycle_q;
    assign running     = running_q;
    assign finished    = finished_q;
    assign passed      = passed_q;
    assign timeout     = timeout_q;
endmodule

// File: tb/tb_sim_check_monitor.sv
// Directed bench for sim_check_monitor: lifecycle, classification, failure log and timeout.

module tb_sim_check_monitor;
    localparam int NUM_CH = 2, XLEN = 32, MAXC = 16, CW = 16, LD = 8;
    localparam logic [31:0] DONE = 32'h0D15EA5E, FAILC = 32'hDEADBEEF;

    logic               clk = 1'b0, rst_n = 1'b0, start = 1'b0, log_ready = 1'b0;
    logic [NUM_CH-1:0]  call_valid = '0;
    logic [63:0]        call_code = '0, call_pc = '0, cmp_a = '0, cmp_b = '0;
    logic               log_valid, running, finished, passed, timeout;
    logic [2:0]         log_ch;
    logic [31:0]        log_pc, log_code;
    logic [CW-1:0]      pass_count, fail_count, drop_count;
    logic [4:0]         cycle_count;
    int                 n_chk = 0, n_err = 0;

    sim_check_monitor #(.NUM_CH(NUM_CH), .XLEN(XLEN), .MAX_CYCLES(MAXC), .CNT_WIDTH(CW),
                        .LOG_DEPTH(LD), .DONE_CODE(DONE), .FAIL_CODE(FAILC)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .call_valid(call_valid),
        .call_code(call_code), .call_pc(call_pc), .cmp_a(cmp_a), .cmp_b(cmp_b),
        .log_valid(log_valid), .log_ready(log_ready), .log_ch(log_ch), .log_pc(log_pc),
        .log_code(log_code), .pass_count(pass_count), .fail_count(fail_count),
        .drop_count(drop_count), .cycle_count(cycle_count), .running(running),
        .finished(finished), .passed(passed), .timeout(timeout)
    );

    always #5 clk = ~clk;

    // Inputs change and outputs are sampled on the falling edge.
    task automatic step();
        @(negedge clk);
    endtask

    task automatic do_reset();
        call_valid = '0; start = 1'b0; log_ready = 1'b0;
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        step();
    endtask

    task automatic do_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        n_chk++; if ({running, finished, passed, timeout, log_valid} !== 5'b0) begin
            n_err++; $display("FAIL reset_status: got %b expected 00000", {running, finished, passed, timeout, log_valid}); end
        n_chk++; if ({pass_count, fail_count, drop_count} !== 48'h0) begin
            n_err++; $display("FAIL reset_counters: got %h expected 0", {pass_count, fail_count, drop_count}); end
        n_chk++; if ({log_ch, log_pc, log_code, cycle_count} !== '0) begin
            n_err++; $display("FAIL reset_log: got %h expected 0", {log_ch, log_pc, log_code, cycle_count}); end
        do_reset();
    endtask

    task automatic test_pass();
        do_reset(); do_start();
        n_chk++; if (running !== 1'b1 || cycle_count !== 5'd0) begin
            n_err++; $display("FAIL pass_running: got run=%b cyc=%0d expected 1/0", running, cycle_count); end
        call_valid = 2'b01; call_code[31:0] = 32'h0; cmp_a[31:0] = 32'd5; cmp_b[31:0] = 32'd5;
        step();
        call_valid = 2'b10; call_code[63:32] = DONE;
        step();
        call_valid = 2'b01; call_code[31:0] = DONE;
        step();
        call_valid = 2'b00;
        n_chk++; if ({finished, passed, running, log_valid} !== 4'b1100) begin
            n_err++; $display("FAIL pass_status: got %b expected 1100", {finished, passed, running, log_valid}); end
        n_chk++; if (pass_count !== 16'd1 || fail_count !== 16'd0) begin
            n_err++; $display("FAIL pass_counts: got p=%0d f=%0d expected 1/0", pass_count, fail_count); end
        n_chk++; if (cycle_count !== 5'd3) begin
            n_err++; $display("FAIL pass_cycles: got %0d expected 3", cycle_count); end
    endtask

    task automatic test_compare_fail();
        do_reset(); do_start();
        call_valid = 2'b10; call_code[63:32] = 32'h0; cmp_a[63:32] = 32'd3; cmp_b[63:32] = 32'd4;
        call_pc[63:32] = 32'h100;
        step();
        call_valid = 2'b00;
        n_chk++; if (fail_count !== 16'd1 || pass_count !== 16'd0) begin
            n_err++; $display("FAIL cmp_counts: got f=%0d p=%0d expected 1/0", fail_count, pass_count); end
        n_chk++; if ({log_valid, log_ch, log_pc, log_code} !== {1'b1, 3'd1, 32'h100, 32'h0}) begin
            n_err++; $display("FAIL cmp_head: got v=%b ch=%0d pc=%h code=%h expected 1/1/100/0", log_valid, log_ch, log_pc, log_code); end
        log_ready = 1'b1;
        step();
        log_ready = 1'b0;
        n_chk++; if (log_valid !== 1'b0) begin
            n_err++; $display("FAIL cmp_pop: got log_valid=%b expected 0", log_valid); end
    endtask

    task automatic test_simultaneous();
        do_reset(); do_start();
        call_valid = 2'b11; call_code = {32'd1, 32'd1}; call_pc = {32'h300, 32'h200};
        step();
        call_valid = 2'b00;
        n_chk++; if (fail_count !== 16'd2 || drop_count !== 16'd1) begin
            n_err++; $display("FAIL sim_counts: got f=%0d d=%0d expected 2/1", fail_count, drop_count); end
        n_chk++; if ({log_valid, log_ch, log_pc, log_code} !== {1'b1, 3'd0, 32'h200, 32'd1}) begin
            n_err++; $display("FAIL sim_head: got v=%b ch=%0d pc=%h code=%h expected 1/0/200/1", log_valid, log_ch, log_pc, log_code); end
        log_ready = 1'b1;
        step();
        log_ready = 1'b0;
        n_chk++; if (log_valid !== 1'b0) begin
            n_err++; $display("FAIL sim_one_record: got log_valid=%b expected 0", log_valid); end
    endtask

    task automatic test_overflow();
        int pops;
        do_reset(); do_start();
        call_code[31:0] = 32'd1;
        for (int i = 0; i < 10; i++) begin
            call_valid = 2'b01; call_pc[31:0] = 32'h40 + i;
            step();
        end
        call_valid = 2'b00;
        n_chk++; if (fail_count !== 16'd10 || drop_count !== 16'd2) begin
            n_err++; $display("FAIL ovf_counts: got f=%0d d=%0d expected 10/2", fail_count, drop_count); end
        n_chk++; if (log_valid !== 1'b1 || log_pc !== 32'h40) begin
            n_err++; $display("FAIL ovf_head: got v=%b pc=%h expected 1/40", log_valid, log_pc); end
        log_ready = 1'b1;
        for (int i = 10; i < 13; i++) begin
            call_valid = 2'b01; call_pc[31:0] = 32'h40 + i;
            step();
        end
        call_valid = 2'b00;
        n_chk++; if (fail_count !== 16'd13 || drop_count !== 16'd2) begin
            n_err++; $display("FAIL ovf_popping: got f=%0d d=%0d expected 13/2", fail_count, drop_count); end
        n_chk++; if (log_pc !== 32'h43) begin
            n_err++; $display("FAIL ovf_order: got pc=%h expected 43", log_pc); end
        pops = 0;
        while (log_valid && pops < 20) begin
            pops++;
            step();
        end
        log_ready = 1'b0;
        n_chk++; if (pops !== 8) begin
            n_err++; $display("FAIL ovf_drain: got %0d records expected 8", pops); end
    endtask

    task automatic test_timeout();
        int waited;
        do_reset(); do_start();
        waited = 0;
        while (!finished && waited < 40) begin
            waited++;
            step();
        end
        n_chk++; if (finished !== 1'b1 || waited !== 16) begin
            n_err++; $display("FAIL to_wait: got fin=%b after %0d cycles expected 1 after 16", finished, waited); end
        n_chk++; if ({cycle_count, timeout, passed, running} !== {5'd15, 3'b100}) begin
            n_err++; $display("FAIL to_status: got cyc=%0d to=%b pa=%b run=%b expected 15/1/0/0", cycle_count, timeout, passed, running); end
        call_valid = 2'b01; call_code[31:0] = 32'd1; start = 1'b1;
        step();
        call_valid = 2'b00; start = 1'b0;
        step();
        n_chk++; if ({fail_count, drop_count, log_valid} !== 33'h0) begin
            n_err++; $display("FAIL to_ignored: got f=%0d d=%0d v=%b expected 0/0/0", fail_count, drop_count, log_valid); end
        n_chk++; if (finished !== 1'b1 || running !== 1'b0 || cycle_count !== 5'd15) begin
            n_err++; $display("FAIL to_sticky: got fin=%b run=%b cyc=%0d expected 1/0/15", finished, running, cycle_count); end
    endtask

    task automatic test_fatal_and_reset();
        do_reset(); do_start();
        call_valid = 2'b10; call_code[63:32] = DONE;
        step();
        call_valid = 2'b11; call_code = {FAILC, DONE}; call_pc[63:32] = 32'h500;
        step();
        call_valid = 2'b00;
        n_chk++; if ({finished, timeout, passed} !== 3'b100 || fail_count !== 16'd1) begin
            n_err++; $display("FAIL fatal_status: got fin=%b to=%b pa=%b f=%0d expected 1/0/0/1", finished, timeout, passed, fail_count); end
        n_chk++; if ({log_valid, log_ch, log_pc, log_code} !== {1'b1, 3'd1, 32'h500, FAILC}) begin
            n_err++; $display("FAIL fatal_head: got v=%b ch=%0d pc=%h code=%h expected 1/1/500/deadbeef", log_valid, log_ch, log_pc, log_code); end
        do_reset(); do_start();
        call_valid = 2'b01; call_code[31:0] = 32'd7;
        step();
        call_valid = 2'b00;
        step();
        n_chk++; if (log_valid !== 1'b1 || fail_count !== 16'd0 || running !== 1'b1) begin
            n_err++; $display("FAIL other_code: got v=%b f=%0d run=%b expected 1/0/1", log_valid, fail_count, running); end
        rst_n = 1'b0;
        #2;
        n_chk++; if ({running, finished, passed, timeout, log_valid, log_pc, cycle_count, fail_count} !== '0) begin
            n_err++; $display("FAIL midrun_reset: got run=%b fin=%b v=%b cyc=%0d expected all 0", running, finished, log_valid, cycle_count); end
        step();
        rst_n = 1'b1;
        step();
    endtask

    initial begin
        test_reset();
        test_pass();
        test_compare_fail();
        test_simultaneous();
        test_overflow();
        test_timeout();
        test_fatal_and_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
        $finish;
    end
endmodule

// File: doc/sim_check_monitor.md
Name: sim_check_monitor

Overview:
- Synthesizable, multi-channel successor to the core self-check bench logic.
- Watches sim-call events (FENCE retire plus mscratch code) from NUM_CH harts/cores and classifies each call.
- Counts passes and failures, detects done, fail and timeout, and keeps a FIFO log of failure records.
- Sits beside the core(s) in simulation and FPGA bring-up; the log drains to a UART or debug reader.

Parameters:
NUM_CH, 2, number of monitored channels (1..8)
XLEN, 32, data/address width
MAX_CYCLES, 2048, timeout limit in cycles counted in RUN
CNT_WIDTH, 16, width of pass/fail/drop counters
LOG_DEPTH, 8, failure-log FIFO depth (power of 2, >=2)
DONE_CODE, 32'h0D15EA5E, code for the done sim call
FAIL_CODE, 32'hDEADBEEF, code for the fatal-fail sim call

Ports:
clk  in  1  system clock
rst_n  in  1  reset; asynchronous, active-low
start  in  1  pulse; IDLE->RUN
call_valid  in  NUM_CH  per-channel sim-call strobe (FENCE retire)
call_code  in  NUM_CH*XLEN  mscratch value per channel
call_pc  in  NUM_CH*XLEN  ra-4 of the caller per channel
cmp_a  in  NUM_CH*XLEN  x10 per channel
cmp_b  in  NUM_CH*XLEN  x11 per channel
log_valid  out  1  FIFO not empty
log_ready  in  1  consumer pops when log_valid&&log_ready
log_ch  out  3  channel of the head record
log_pc  out  XLEN  pc of the head record
log_code  out  XLEN  code of the head record
pass_count  out  CNT_WIDTH  passed compares
fail_count  out  CNT_WIDTH  failed checks
drop_count  out  CNT_WIDTH  failure records not logged
cycle_count  out  $clog2(MAX_CYCLES+1)  cycles spent in RUN
running  out  1  state==RUN
finished  out  1  state==END
passed  out  1  END && fail_count==0 && all ch done && !timeout
timeout  out  1  END reached by cycle limit

Behaviour:
- Reset (async, rst_n=0): state IDLE. All counters 0. ch_done all 0. FIFO empty (log_valid=0). log_ch, log_pc, log_code all 0. Every status output 0.
- States: IDLE --start--> RUN.
- RUN --(all ch_done) | (any FAIL_CODE call) | (cycle_count==MAX_CYCLES-1)--> END.
- END exits only on reset. start is ignored outside IDLE.
- cycle_count increments each RUN cycle. It freezes in END. timeout=1 only when the limit caused the exit.
- Calls are sampled only in RUN. In IDLE and END they are ignored with no count changes. Per valid channel, classify the call:
  - code 0: if cmp_a==cmp_b then pass+1; otherwise fail+1 and a failure record.
  - code 1: fail+1 and a failure record.
  - DONE_CODE: set ch_done[ch]. A repeat DONE call has no effect.
  - FAIL_CODE: fail+1, a failure record, and END on the next cycle.
  - any other code: failure record only. fail_count does not change.
  - A call from a channel with ch_done set is still classified.
- Same-cycle calls:
  - Counters add the number of events per class across channels (popcount).
  - A RUN-exit cause that coincides with calls still counts those calls.
  - If timeout coincides with done/FAIL, timeout=0.
- Counters saturate at all-ones and never wrap.
- Failure log:
  - At most one push per cycle; the lowest-index failing channel wins.
  - Every other record in that cycle increments drop_count, and so does a push attempt while the FIFO is full.
  - Record = {ch, pc, code}. For code 0 the logged code field is 0.
- FIFO is first-word-fall-through with registered outputs; push-to-log_valid latency is 1 cycle.
- Simultaneous push and pop while full succeeds with no drop. Pop on empty is ignored. Pointers wrap modulo LOG_DEPTH.
- The log stays poppable in END.
- Reset mid-run returns to IDLE and clears everything, including FIFO contents.

Test Plan:
- Pass case, NUM_CH=2: start; ch0 code 0 with a=b=5; ch1 DONE; ch0 DONE -> pass_count=1, finished and passed=1 one cycle after the second DONE, log_valid=0.
- Compare fail: ch1 code 0 with a=3, b=4, pc=0x100 -> fail_count=1; log head {1, 0x100, 0} after 1 cycle; pop clears log_valid.
- Simultaneous fails: ch0 and ch1 both code 1 in the same cycle -> fail_count=2, one record (ch0), drop_count=1.
- FIFO overflow, LOG_DEPTH=8, log_ready=0: 10 single fails -> 8 records, drop_count=2. Then hold log_ready=1 with one fail per cycle -> no new drops.
- Timeout, MAX_CYCLES=16: start and issue no calls -> END with cycle_count=15, timeout=1, passed=0. A later call leaves the counters unchanged.
- FAIL_CODE from ch1 in the same cycle as ch0's last DONE -> fail_count=1, timeout=0, passed=0. Reset pulse mid-RUN -> all outputs 0 and state IDLE.
